// File: rtl/axo32_operand_stage.sv
// Operand-fetch/issue stage ahead of the RV32IM ALU: forwarding, immediate select,
// load-use stall, and a one-entry valid/ready register holding lhs/rhs/insn.
module axo32_operand_stage #(
    parameter logic [31:0] RESET_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_insn,
    input  logic [31:0] in_pc,
    input  logic [31:0] rf_rs1,
    input  logic [31:0] rf_rs2,
    input  logic        fa_valid,
    input  logic [4:0]  fa_rd,
    input  logic [31:0] fa_data,
    input  logic        fa_pending,
    input  logic        fb_valid,
    input  logic [4:0]  fb_rd,
    input  logic [31:0] fb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_lhs,
    output logic [31:0] out_rhs,
    output logic [31:0] out_insn,
    output logic [31:0] out_pc,
    output logic [31:0] out_rs1,
    output logic [31:0] out_rs2
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_ST    = 7'b0100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    typedef struct packed {
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [31:0] insn;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } entry_t;

    entry_t     ent_q, ent_d;
    logic       vld_q;
    logic [6:0] opc;
    logic [4:0] rs1_idx, rs2_idx;
    logic [31:0] imm_i, imm_s, imm_u;
    logic       use1, use2, hazard, accept;

    // Port A is the younger producer, so it shadows port B.
    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf,
                                        input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                        input logic bv, input logic [4:0] brd, input logic [31:0] bd);
        if (idx == 5'd0)              return 32'd0;
        else if (av && ard == idx)    return ad;
        else if (bv && brd == idx)    return bd;
        else                          return rf;
    endfunction

    assign opc     = in_insn[6:0];
    assign rs1_idx = in_insn[19:15];
    assign rs2_idx = in_insn[24:20];
    assign imm_i   = {{20{in_insn[31]}}, in_insn[31:20]};
    assign imm_s   = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
    assign imm_u   = {in_insn[31:12], 12'b0};

    always_comb begin
        ent_d      = '0;
        ent_d.insn = in_insn;
        ent_d.pc   = in_pc;
        ent_d.rs1  = fwd(rs1_idx, rf_rs1, fa_valid, fa_rd, fa_data, fb_valid, fb_rd, fb_data);
        ent_d.rs2  = fwd(rs2_idx, rf_rs2, fa_valid, fa_rd, fa_data, fb_valid, fb_rd, fb_data);
        ent_d.lhs  = ent_d.rs1;
        ent_d.rhs  = imm_i;
        unique case (opc)
            OPC_OP, OPC_BR:     ent_d.rhs = ent_d.rs2;
            OPC_IMM, OPC_LD:    ent_d.rhs = imm_i;
            OPC_ST:             ent_d.rhs = imm_s;
            OPC_LUI:            begin ent_d.lhs = 32'd0; ent_d.rhs = imm_u; end
            OPC_AUIPC:          begin ent_d.lhs = in_pc; ent_d.rhs = imm_u; end
            OPC_JAL, OPC_JALR:  begin ent_d.lhs = in_pc; ent_d.rhs = 32'd4; end
            default:            ;
        endcase
    end

    always_comb begin
        use1 = 1'b0;
        use2 = 1'b0;
        case (opc)
            OPC_OP, OPC_BR, OPC_ST:   begin use1 = 1'b1; use2 = 1'b1; end
            OPC_IMM, OPC_LD, OPC_JALR: use1 = 1'b1;
            default: ;
        endcase
    end

    // Only a pending load on port A can stall; port B data is always ready.
    assign hazard   = in_valid && fa_valid && fa_pending && (fa_rd != 5'd0) &&
                      ((use1 && fa_rd == rs1_idx) || (use2 && fa_rd == rs2_idx));
    assign in_ready = !hazard && (!vld_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= 1'b0;
            ent_q      <= '0;
            ent_q.insn <= RESET_INSN;
        end else if (flush) begin
            vld_q      <= 1'b0;
            ent_q.insn <= RESET_INSN;
        end else if (accept) begin
            vld_q <= 1'b1;
            ent_q <= ent_d;
        end else if (out_ready) begin
            vld_q <= 1'b0;
        end
    end

    assign out_valid = vld_q;
    assign out_lhs   = ent_q.lhs;
    assign out_rhs   = ent_q.rhs;
    assign out_insn  = ent_q.insn;
    assign out_pc    = ent_q.pc;
    assign out_rs1   = ent_q.rs1;
    assign out_rs2   = ent_q.rs2;
endmodule

// File: tb/tb_axo32_operand_stage.sv
// Scoreboard bench for axo32_operand_stage: directed cases then randomized traffic,
// expected entries computed from RISC-V operand rules and checked by a monitor.
module tb_axo32_operand_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, in_ready;
    logic [31:0] in_insn = '0, in_pc = '0, rf_rs1 = '0, rf_rs2 = '0;
    logic        fa_valid = 1'b0, fa_pending = 1'b0, fb_valid = 1'b0;
    logic [4:0]  fa_rd = '0, fb_rd = '0;
    logic [31:0] fa_data = '0, fb_data = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] out_lhs, out_rhs, out_insn, out_pc, out_rs1, out_rs2;

    axo32_operand_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .fa_valid(fa_valid), .fa_rd(fa_rd), .fa_data(fa_data), .fa_pending(fa_pending),
        .fb_valid(fb_valid), .fb_rd(fb_rd), .fb_data(fb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lhs(out_lhs), .out_rhs(out_rhs), .out_insn(out_insn), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2)
    );

    typedef struct {
        logic [31:0] lhs, rhs, insn, pc, rs1, rs2;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0, held = 0;
    bit   pushed = 0, chk_rst = 0, chk_clr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] regval(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return 32'd0;
        if (fa_valid && fa_rd == idx) return fa_data;
        if (fb_valid && fb_rd == idx) return fb_data;
        return rf;
    endfunction

    function automatic exp_t model();
        exp_t e;
        logic signed [31:0] w;
        logic [31:0] ii, s, u, a, b;
        w  = $signed(in_insn);
        ii = w >>> 20;
        s  = (ii & ~32'h1f) | {27'd0, in_insn[11:7]};
        u  = in_insn & 32'hFFFF_F000;
        a  = regval(in_insn[19:15], rf_rs1);
        b  = regval(in_insn[24:20], rf_rs2);
        e.insn = in_insn; e.pc = in_pc; e.rs1 = a; e.rs2 = b;
        case (in_insn[6:0])
            7'h33, 7'h63: begin e.lhs = a;     e.rhs = b;     end
            7'h13, 7'h03: begin e.lhs = a;     e.rhs = ii;    end
            7'h23:        begin e.lhs = a;     e.rhs = s;     end
            7'h37:        begin e.lhs = 0;     e.rhs = u;     end
            7'h17:        begin e.lhs = in_pc; e.rhs = u;     end
            7'h6f, 7'h67: begin e.lhs = in_pc; e.rhs = 32'd4; end
            default:      begin e.lhs = a;     e.rhs = ii;    end
        endcase
        return e;
    endfunction

    function automatic bit stall();
        logic [6:0] op;
        bit u1, u2;
        op = in_insn[6:0];
        if (!in_valid || !fa_valid || !fa_pending || fa_rd == 0) return 0;
        u1 = op inside {7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h67};
        u2 = op inside {7'h33, 7'h63, 7'h23};
        return (u1 && fa_rd == in_insn[19:15]) || (u2 && fa_rd == in_insn[24:20]);
    endfunction

    task automatic drive(input logic iv, input logic [31:0] insn, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic fav, input logic [4:0] fard, input logic [31:0] fad, input logic fap,
                         input logic fbv, input logic [4:0] fbrd, input logic [31:0] fbd,
                         input logic ordy, input logic fl, input logic rs);
        bit exp_rdy;
        @(posedge clk);
        #2;
        in_valid = iv; in_insn = insn; in_pc = pc; rf_rs1 = r1; rf_rs2 = r2;
        fa_valid = fav; fa_rd = fard; fa_data = fad; fa_pending = fap;
        fb_valid = fbv; fb_rd = fbrd; fb_data = fbd;
        out_ready = ordy; flush = fl; rst = rs;
        #1;
        if (!rs) begin
            exp_rdy = !stall() && (q.size() == 0 || ordy);
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            if (iv && exp_rdy && !fl) begin
                q.push_back(model());
                pushed = 1;
            end
        end
    endtask

    task automatic idle(input logic ordy);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ordy, 0, 0);
    endtask

    // Monitor: compares the held entry against the queue head, then retires it on handshake.
    always @(negedge clk) begin
        held = q.size() - int'(pushed);
        if (chk_rst) begin
            chk("rst_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_insn", out_insn, 32'h0000_0013);
            chk("rst_lhs", out_lhs, 32'd0);
            chk("rst_rhs", out_rhs, 32'd0);
            chk("rst_pc", out_pc, 32'd0);
            chk("rst_rs1", out_rs1, 32'd0);
            chk("rst_rs2", out_rs2, 32'd0);
        end else begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, held != 0});
            if (out_valid && held != 0) begin
                chk("lhs", out_lhs, q[0].lhs);
                chk("rhs", out_rhs, q[0].rhs);
                chk("insn", out_insn, q[0].insn);
                chk("pc", out_pc, q[0].pc);
                chk("rs1", out_rs1, q[0].rs1);
                chk("rs2", out_rs2, q[0].rs2);
            end
            if (chk_clr && !out_valid) chk("clr_insn", out_insn, 32'h0000_0013);
        end
        if (out_valid) chk_clr = 0;
        if (rst || flush) begin
            q.delete();
            chk_clr = 1;
        end else if (out_valid && out_ready && held != 0) begin
            void'(q.pop_front());
        end
        chk_rst = rst;
        pushed  = 0;
    end

    logic [6:0]  ops [10] = '{7'h33, 7'h63, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h7f};
    logic [31:0] rinsn;
    int          k;

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(1);
        // ADD x3,x1,x2 with plain regfile data
        drive(1, 32'h0020_81B3, 32'h100, 5, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        // ADDI x1,x1,-1: port A shadows port B
        drive(1, 32'hFFF0_8093, 32'h104, 32'h55, 0, 1, 1, 32'h10, 0, 1, 1, 32'h20, 1, 0, 0);
        idle(1);
        // BEQ x1,x2 stalls on pending x2 until it resolves
        drive(1, 32'h0020_8063, 32'h108, 3, 4, 1, 2, 32'h99, 1, 0, 0, 0, 1, 0, 0);
        drive(1, 32'h0020_8063, 32'h108, 3, 4, 1, 2, 32'h99, 1, 0, 0, 0, 1, 0, 0);
        drive(1, 32'h0020_8063, 32'h108, 3, 4, 1, 2, 32'h99, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        // ADDI x3,x2,0 stalls; LUI x3 ignores the pending producer
        drive(1, 32'h0001_0193, 32'h10C, 8, 9, 1, 2, 32'h77, 1, 0, 0, 0, 1, 0, 0);
        drive(1, 32'h1234_51B7, 32'h110, 8, 9, 1, 2, 32'h77, 1, 0, 0, 0, 1, 0, 0);
        idle(1);
        // back-pressure: entry must hold while out_ready is low
        drive(1, 32'h0020_81B3, 32'h114, 11, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            drive(1, 32'h0020_8133, 32'h118, 13, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 32'h0020_8133, 32'h118, 13, 14, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        idle(1);
        // flush in the same cycle as an accept
        drive(1, 32'h0020_81B3, 32'h11C, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        idle(1);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 9);
            rinsn = $urandom;
            rinsn[6:0]   = (k == 9) ? 7'($urandom) : ops[k];
            rinsn[19:15] = 5'($urandom_range(0, 3));
            rinsn[24:20] = 5'($urandom_range(0, 3));
            drive(1'($urandom_range(0, 3) != 0), rinsn, $urandom, $urandom, $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 29) == 0),
                  1'($urandom_range(0, 199) == 0));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(1);
        idle(1);
        idle(1);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
